// File: rtl/nibble_serial_addsub.sv
// Multi-cycle 16-bit signed add/subtract built around one shared 4-bit
// carry-lookahead slice that processes one nibble per cycle, with signed
// saturation and ALU flags on the final result.
module nibble_serial_addsub #(
  parameter int unsigned NIB_W   = 4,
  parameter int unsigned NUM_NIB = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     sub,
  input  logic [NIB_W*NUM_NIB-1:0] A,
  input  logic [NIB_W*NUM_NIB-1:0] B,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NUM_NIB-1:0] result,
  output logic                     ovfl,
  output logic                     zero,
  output logic                     neg
);

  localparam int unsigned W     = NIB_W * NUM_NIB;
  localparam int unsigned IDX_W = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);
  localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_SAT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     result_q, result_d;
  logic             ovfl_q, ovfl_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  logic [NIB_W-1:0] a_nib_c, b_nib_c, nib_sum_c;
  logic [NIB_W-1:0] g_c, p_c;
  logic [NIB_W:0]   cl_c;
  logic             grp_g_c, grp_p_c, nib_cout_c;
  logic             ovf_c;
  logic [W-1:0]     sat_val_c;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    a_nib_c = '0;
    b_nib_c = '0;
    for (int n = 0; n < NUM_NIB; n++) begin
      if (idx_q == IDX_W'(n)) begin
        a_nib_c = a_q[n*NIB_W +: NIB_W];
        b_nib_c = b_q[n*NIB_W +: NIB_W];
      end
    end
  end

  // 4-bit carry-lookahead slice: internal carries and group carry-out G | P&Cin.
  always_comb begin
    g_c        = a_nib_c & b_nib_c;
    p_c        = a_nib_c ^ b_nib_c;
    cl_c       = '0;
    cl_c[0]    = carry_q;
    cl_c[1]    = g_c[0] | (p_c[0] & carry_q);
    cl_c[2]    = g_c[1] | (p_c[1] & g_c[0]) | (p_c[1] & p_c[0] & carry_q);
    cl_c[3]    = g_c[2] | (p_c[2] & g_c[1]) | (p_c[2] & p_c[1] & g_c[0])
               | (p_c[2] & p_c[1] & p_c[0] & carry_q);
    grp_g_c    = g_c[3] | (p_c[3] & g_c[2]) | (p_c[3] & p_c[2] & g_c[1])
               | (p_c[3] & p_c[2] & p_c[1] & g_c[0]);
    grp_p_c    = &p_c;
    nib_cout_c = grp_g_c | (grp_p_c & carry_q);
    cl_c[4]    = nib_cout_c;
    nib_sum_c  = p_c ^ cl_c[NIB_W-1:0];
  end

  // Signed overflow detection and saturated value from the completed sum.
  always_comb begin
    ovf_c     = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);
    sat_val_c = sum_q;
    if (ovf_c) begin
      sat_val_c = a_q[W-1] ? SAT_MIN : SAT_MAX;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovfl_d   = ovfl_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    case (state_q)
      S_IDLE: begin
        // busy spans the done cycle; it drops on the edge after it
        if (done_q) begin
          busy_d = 1'b0;
        end
        if (start && !busy_q) begin
          a_d     = A;
          b_d     = sub ? ~B : B;
          carry_d = sub;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int n = 0; n < NUM_NIB; n++) begin
          if (idx_q == IDX_W'(n)) begin
            sum_d[n*NIB_W +: NIB_W] = nib_sum_c;
          end
        end
        carry_d = nib_cout_c;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = S_SAT;
        end
      end
      S_SAT: begin
        result_d = sat_val_c;
        ovfl_d   = ovf_c;
        zero_d   = (sat_val_c == '0);
        neg_d    = sat_val_c[W-1];
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovfl_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovfl_q   <= ovfl_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovfl   = ovfl_q;
  assign zero   = zero_q;
  assign neg    = neg_q;

endmodule
